// File: rtl/multi_band_centroid_pkg.sv
// Shared types and width helpers for the multi-band centroid block.
package centroid_pkg;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_LOAD = 2'd1,
    DS_DIV  = 2'd2,
    DS_DONE = 2'd3
  } div_state_t;

  typedef struct packed {
    logic [7:0]  idx;
    logic [15:0] cx;
    logic        lost;
  } band_result_t;

  function automatic int cx_w(input int img_w);
    return $clog2(img_w) + 1;
  endfunction

  function automatic int sw_w(input int wgt_w, input int img_w, input int band_h);
    return wgt_w + $clog2(img_w * band_h);
  endfunction

  function automatic int sxw_w(input int sw, input int img_w);
    return sw + $clog2(img_w);
  endfunction

endpackage

// File: rtl/multi_band_centroid_if.sv
// Pixel-in / band-result bus of the multi-band centroid.
interface multi_band_centroid_if #(
  parameter int IMG_W     = 640,
  parameter int PIX_W     = 4,
  parameter int NUM_BANDS = 4
);
  localparam int CX_W = $clog2(IMG_W) + 1;
  localparam int BI_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;

  logic [PIX_W-1:0]     pixel_in;
  logic                 in_ready;
  logic                 band_valid;
  logic [BI_W-1:0]      band_idx;
  logic [CX_W-1:0]      centroid_x;
  logic                 band_lost;
  logic                 frame_done;
  logic [NUM_BANDS-1:0] lost_mask;

  modport master (output pixel_in, in_ready,
                  input  band_valid, band_idx, centroid_x, band_lost, frame_done, lost_mask);
  modport slave  (input  pixel_in, in_ready,
                  output band_valid, band_idx, centroid_x, band_lost, frame_done, lost_mask);
endinterface

// File: rtl/multi_band_centroid_seq_divider.sv
// Restoring divider, one quotient bit per cycle; done is high for the single DONE cycle.
module seq_divider
  import centroid_pkg::*;
#(
  parameter int DD_W = 13,
  parameter int DS_W = 9,
  parameter int Q_W  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [DD_W-1:0] i_dividend,
  input  logic [DS_W-1:0] i_divisor,
  output logic            o_done,
  output logic [Q_W-1:0]  o_quot
);
  localparam int R_W = DS_W + 1;
  localparam int C_W = $clog2(Q_W + 1);

  div_state_t      r_state;
  logic [DD_W-1:0] r_dvd;
  logic [DS_W-1:0] r_dvs;
  logic [R_W-1:0]  r_rem;
  logic [Q_W-1:0]  r_q;
  logic [C_W-1:0]  r_cnt;
  logic [R_W-1:0]  w_trial;
  logic            w_qbit;

  // Quotient fits Q_W bits, so the dividend bits above Q_W seed the remainder directly.
  assign w_trial = {r_rem[R_W-2:0], r_q[Q_W-1]};
  assign w_qbit  = w_trial >= {1'b0, r_dvs};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DS_IDLE;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        DS_IDLE: if (i_start) begin
          r_dvd   <= i_dividend;
          r_dvs   <= i_divisor;
          r_state <= DS_LOAD;
        end
        DS_LOAD: begin
          r_rem   <= R_W'(r_dvd >> Q_W);
          r_q     <= r_dvd[Q_W-1:0];
          r_cnt   <= '0;
          r_state <= DS_DIV;
        end
        DS_DIV: begin
          r_rem <= w_qbit ? (w_trial - {1'b0, r_dvs}) : w_trial;
          r_q   <= {r_q[Q_W-2:0], w_qbit};
          r_cnt <= r_cnt + C_W'(1);
          if (r_cnt == C_W'(Q_W - 1)) r_state <= DS_DONE;
        end
        DS_DONE: r_state <= DS_IDLE;
        default: r_state <= DS_IDLE;
      endcase
    end
  end

  assign o_done = (r_state == DS_DONE);
  assign o_quot = r_q;
endmodule

// File: rtl/multi_band_centroid.sv
// Per-band intensity-weighted horizontal centroid over the bottom NUM_BANDS*BAND_H rows.
// Define CENTROID_WEIGHTED_EN for intensity weights; binary weights otherwise.
module multi_band_centroid
  import centroid_pkg::*;
#(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int PIX_W     = 4,
  parameter int NUM_BANDS = 4,
  parameter int BAND_H    = 15,
  parameter int THRESHOLD = 0,
  parameter int MIN_COUNT = 1
) (
  input logic clk,
  input logic rst,
  multi_band_centroid_if.slave bus
);
  localparam int CX_W = cx_w(IMG_W);
`ifdef CENTROID_WEIGHTED_EN
  localparam int WGT_W = PIX_W;
`else
  localparam int WGT_W = 1;
`endif
  localparam int SW_W    = sw_w(WGT_W, IMG_W, BAND_H);
  localparam int SXW_W   = sxw_w(SW_W, IMG_W);
  localparam int X_W     = $clog2(IMG_W);
  localparam int Y_W     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int BI_W    = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int RB_W    = (BAND_H > 1) ? $clog2(BAND_H) : 1;
  localparam int ROI_TOP = IMG_H - NUM_BANDS * BAND_H;

  if (NUM_BANDS * BAND_H > IMG_H) begin : g_chk_roi
    $error("bands do not fit in the frame");
  end
  if (BAND_H < 1) begin : g_chk_bh
    $error("BAND_H must be at least 1");
  end
  if (IMG_W < CX_W + 3) begin : g_chk_w
    $error("rows too short for the divider to finish between bands");
  end

  logic [X_W-1:0]       r_x;
  logic [Y_W-1:0]       r_y;
  logic [RB_W-1:0]      r_brow;
  logic [BI_W-1:0]      r_band;
  logic [SW_W-1:0]      r_sw;
  logic [SXW_W-1:0]     r_sxw;
  band_result_t         r_pend, r_res;
  logic                 r_valid, r_fdone;
  logic [NUM_BANDS-1:0] r_lost_acc, r_lost_mask;

  logic                 w_in_roi, w_close, w_above, w_div_done, w_last;
  logic [WGT_W-1:0]     w_w;
  logic [SW_W-1:0]      w_sw_nxt;
  logic [SXW_W-1:0]     w_sxw_nxt;
  logic [CX_W-1:0]      w_quot;
  logic [NUM_BANDS-1:0] w_lost_acc_nxt;
  logic                 w_unused;

  assign w_in_roi = r_y >= Y_W'(ROI_TOP);
  assign w_close  = bus.in_ready && w_in_roi && (r_x == X_W'(IMG_W - 1)) &&
                    (r_brow == RB_W'(BAND_H - 1));
  assign w_above  = bus.pixel_in > PIX_W'(THRESHOLD);
`ifdef CENTROID_WEIGHTED_EN
  assign w_w = w_above ? bus.pixel_in : '0;
`else
  assign w_w = w_above;
`endif
  assign w_sw_nxt  = r_sw + SW_W'(w_w);
  assign w_sxw_nxt = r_sxw + SXW_W'(r_x) * SXW_W'(w_w);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_brow <= '0;
      r_band <= '0;
    end else if (bus.in_ready) begin
      if (r_x == X_W'(IMG_W - 1)) begin
        r_x <= '0;
        r_y <= (r_y == Y_W'(IMG_H - 1)) ? '0 : r_y + Y_W'(1);
        if (w_in_roi) begin
          if (r_brow == RB_W'(BAND_H - 1)) begin
            r_brow <= '0;
            r_band <= (r_band == BI_W'(NUM_BANDS - 1)) ? '0 : r_band + BI_W'(1);
          end else begin
            r_brow <= r_brow + RB_W'(1);
          end
        end
      end else begin
        r_x <= r_x + X_W'(1);
      end
    end
  end

  // The closing pixel goes straight to the divider; the sums restart at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw   <= '0;
      r_sxw  <= '0;
      r_pend <= '0;
    end else if (bus.in_ready && w_in_roi) begin
      if (w_close) begin
        r_sw        <= '0;
        r_sxw       <= '0;
        r_pend.idx  <= 8'(r_band);
        r_pend.lost <= w_sw_nxt < SW_W'(MIN_COUNT);
      end else begin
        r_sw  <= w_sw_nxt;
        r_sxw <= w_sxw_nxt;
      end
    end
  end

  seq_divider #(.DD_W(SXW_W), .DS_W(SW_W), .Q_W(CX_W)) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_close),
    .i_dividend (w_sxw_nxt),
    .i_divisor  (w_sw_nxt),
    .o_done     (w_div_done),
    .o_quot     (w_quot)
  );

  assign w_last         = r_pend.idx == 8'(NUM_BANDS - 1);
  assign w_lost_acc_nxt = r_lost_acc | (NUM_BANDS'(r_pend.lost) << r_pend.idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_fdone     <= 1'b0;
      r_res       <= '0;
      r_lost_acc  <= '0;
      r_lost_mask <= '0;
    end else begin
      r_valid <= w_div_done;
      r_fdone <= w_div_done && w_last;
      if (w_div_done) begin
        r_res.idx  <= r_pend.idx;
        r_res.lost <= r_pend.lost;
        r_res.cx   <= r_pend.lost ? '0 : 16'(w_quot);
        if (w_last) begin
          r_lost_mask <= w_lost_acc_nxt;
          r_lost_acc  <= '0;
        end else begin
          r_lost_acc  <= w_lost_acc_nxt;
        end
      end
    end
  end

  assign bus.band_valid = r_valid;
  assign bus.band_idx   = r_res.idx[BI_W-1:0];
  assign bus.centroid_x = r_res.cx[CX_W-1:0];
  assign bus.band_lost  = r_res.lost;
  assign bus.frame_done = r_fdone;
  assign bus.lost_mask  = r_lost_mask;
  assign w_unused       = ^{r_res, r_pend};
endmodule
